// File: rtl/ysyx_22050854_pkg.sv
// Shared definitions for the immediate-generation stage: ExtOP encodings
// and the packed entry width used by the skid buffer.
package ysyx_22050854_pkg;

    typedef enum logic [2:0] {
        EXT_I    = 3'b000,
        EXT_U    = 3'b001,
        EXT_S    = 3'b010,
        EXT_B    = 3'b011,
        EXT_J    = 3'b100,
        EXT_RAW7 = 3'b101,
        EXT_ZIMM = 3'b110,
        EXT_ILL  = 3'b111
    } ext_op_e;

    // Entry layout, MSB first: {illegal, tag, imm}.
    function automatic int entry_width(input int xlen, input int tag_w);
        return xlen + tag_w + 1;
    endfunction

endpackage

// File: rtl/ysyx_22050854_imm_dec.sv
// Combinational immediate decoder: instruction + ExtOP -> XLEN immediate
// and an illegal-format flag.
module ysyx_22050854_imm_dec
    import ysyx_22050854_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [31:0]     instr,
    input  logic [2:0]      extop,
    output logic [XLEN-1:0] imm,
    output logic            illegal
);

    logic [63:0] imm64;
    logic        s;
    ext_op_e     op;

    assign s  = instr[31];
    assign op = ext_op_e'(extop);

    // Built at 64 bits and truncated, so XLEN=32 sees identical low bits.
    always_comb begin
        imm64   = '0;
        illegal = 1'b0;
        case (op)
            EXT_I:    imm64 = {{52{s}}, instr[31:20]};
            EXT_U:    imm64 = {{32{s}}, instr[31:12], 12'b0};
            EXT_S:    imm64 = {{52{s}}, instr[31:25], instr[11:7]};
            EXT_B:    imm64 = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            EXT_J:    imm64 = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            EXT_RAW7: imm64 = {57'b0, instr[6:0]};
            EXT_ZIMM: imm64 = {59'b0, instr[19:15]};
            default:  illegal = 1'b1;
        endcase
    end

    assign imm = imm64[XLEN-1:0];

endmodule

// File: rtl/ysyx_22050854_imm_stage.sv
// Registered immediate stage: decodes on the input side, buffers entries in a
// 2-deep skid buffer so out_ready never reaches in_ready combinationally.
module ysyx_22050854_imm_stage
    import ysyx_22050854_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [2:0]       in_extop,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] acc_cnt
);

    localparam int ENTRY_W = entry_width(XLEN, TAG_W);

    logic [XLEN-1:0]    dec_imm;
    logic               dec_illegal;
    logic [ENTRY_W-1:0] in_entry;
    logic [ENTRY_W-1:0] main_q;
    logic [ENTRY_W-1:0] skid_q;
    logic               main_valid;
    logic               skid_valid;
    logic               in_fire;
    logic               out_fire;
    logic               main_load;

    ysyx_22050854_imm_dec #(.XLEN(XLEN)) u_dec (
        .instr   (in_instr),
        .extop   (in_extop),
        .imm     (dec_imm),
        .illegal (dec_illegal)
    );

    // Handshake: a transfer happens on a cycle where valid and ready are both
    // high; valid never depends on ready, and in_ready is a pure register output.
    assign in_ready  = !skid_valid;
    assign out_valid = main_valid;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign main_load = !main_valid | out_fire;
    assign in_entry  = {dec_illegal, in_tag, dec_imm};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
            skid_q     <= '0;
            acc_cnt    <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (in_fire)
                acc_cnt <= acc_cnt + CNT_W'(1);
            if (main_load) begin
                if (skid_valid) begin
                    main_q     <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= in_fire;
                    if (in_fire)
                        skid_q <= in_entry;
                end else if (in_fire) begin
                    main_q     <= in_entry;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (in_fire) begin
                // Main is stalled; park the new entry so FIFO order is kept.
                skid_q     <= in_entry;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_imm     = main_q[XLEN-1:0];
    assign out_tag     = main_q[XLEN+TAG_W-1:XLEN];
    assign out_illegal = main_q[ENTRY_W-1];

endmodule

// File: tb/tb_ysyx_22050854_imm_stage.sv
// Self-checking bench for ysyx_22050854_imm_stage: format table, backpressure,
// streaming, flush, mid-run reset and randomized traffic against a model.
module tb_ysyx_22050854_imm_stage;

    localparam int XLEN  = 64;
    localparam int TAG_W = 64;
    localparam int CNT_W = 32;
    localparam int W     = XLEN + TAG_W + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_extop;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic             out_illegal;
    logic [TAG_W-1:0] out_tag;
    logic [CNT_W-1:0] acc_cnt;

    logic             in_ready32;
    logic             out_valid32;
    logic [31:0]      out_imm32;
    logic             out_illegal32;
    logic [TAG_W-1:0] out_tag32;
    logic [CNT_W-1:0] acc_cnt32;

    ysyx_22050854_imm_stage #(.XLEN(XLEN), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .in_extop(in_extop), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_illegal(out_illegal), .out_tag(out_tag), .acc_cnt(acc_cnt)
    );

    ysyx_22050854_imm_stage #(.XLEN(32), .TAG_W(TAG_W), .CNT_W(CNT_W)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_instr(in_instr),
        .in_extop(in_extop), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(1'b1), .out_imm(out_imm32),
        .out_illegal(out_illegal32), .out_tag(out_tag32), .acc_cnt(acc_cnt32)
    );

    // ---------------- counters / check ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int n_out    = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [W-1:0] ref_entry(input logic [31:0] ins, input logic [2:0] op,
                                               input logic [TAG_W-1:0] tag);
        longint sx;
        longint v;
        logic   ill;
        sx  = longint'($signed(ins));
        v   = 0;
        ill = 1'b0;
        case (op)
            3'd0: v = sx >>> 20;
            3'd1: v = (sx >>> 12) * 4096;
            3'd2: v = (sx >>> 25) * 32 + longint'(ins[11:7]);
            3'd3: v = (sx >>> 31) * 4096 + longint'(ins[7]) * 2048
                      + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
            3'd4: v = (sx >>> 31) * 1048576 + longint'(ins[19:12]) * 4096
                      + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2;
            3'd5: v = longint'(ins) % 128;
            3'd6: v = (longint'(ins) / 32768) % 32;
            default: begin v = 0; ill = 1'b1; end
        endcase
        return {ill, tag, v[XLEN-1:0]};
    endfunction

    // ---------------- scoreboard ----------------
    logic [W-1:0]     exp_q[$];
    logic [CNT_W-1:0] acc_model = '0;

    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst_n) begin
            exp_q.delete();
            acc_model = '0;
        end else begin
            check("acc_cnt", acc_cnt, acc_model);
            check("out_valid_occupancy", out_valid, exp_q.size() != 0);
            check("in_ready_occupancy", in_ready, exp_q.size() < 2);
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got tag %h expected no output", out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_imm", out_imm, e[XLEN-1:0]);
                    check("sb_tag", out_tag, e[XLEN+TAG_W-1:XLEN]);
                    check("sb_illegal", out_illegal, e[W-1]);
                end
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(ref_entry(in_instr, in_extop, in_tag));
                acc_model = acc_model + 1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [2:0] op,
                         input logic [TAG_W-1:0] tag);
        in_valid = v;
        in_instr = ins;
        in_extop = op;
        in_tag   = tag;
    endtask

    task automatic fill_two();
        out_ready = 1'b0;
        drive(1'b1, 32'hFFF00093, 3'd0, 64'hA);
        tick();
        drive(1'b1, 32'h123450B7, 3'd1, 64'hB);
        tick();
    endtask

    typedef struct {
        logic [31:0] instr;
        logic [2:0]  op;
        logic [63:0] imm;
        logic        ill;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [CNT_W-1:0] acc_saved;
        int               n0;

        vecs[0] = '{32'hFFF00093, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0};
        vecs[1] = '{32'h123450B7, 3'd1, 64'h0000000012345000, 1'b0};
        vecs[2] = '{32'hFE113C23, 3'd2, 64'hFFFFFFFFFFFFFFF8, 1'b0};
        vecs[3] = '{32'h00000463, 3'd3, 64'h0000000000000008, 1'b0};
        vecs[4] = '{32'hFFDFF06F, 3'd4, 64'hFFFFFFFFFFFFFFFC, 1'b0};
        vecs[5] = '{32'h00000093, 3'd5, 64'h0000000000000013, 1'b0};
        vecs[6] = '{32'h3002D073, 3'd6, 64'h0000000000000005, 1'b0};
        vecs[7] = '{32'hDEADBEEF, 3'd7, 64'h0000000000000000, 1'b1};

        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 3'd0, '0);
        tick();
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_out_imm", out_imm, '0);
        check("reset_out_tag", out_tag, '0);
        check("reset_out_illegal", out_illegal, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        check("reset_acc_cnt", acc_cnt, '0);
        rst_n = 1'b1;
        tick();

        // Format table: result must appear one cycle after in_fire.
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, vecs[i].instr, vecs[i].op, 64'(100 + i));
            tick();
            drive(1'b0, 32'h0, 3'd0, '0);
            check("tbl_out_valid", out_valid, 1'b1);
            check("tbl_imm", out_imm, vecs[i].imm);
            check("tbl_illegal", out_illegal, vecs[i].ill);
            check("tbl_tag", out_tag, 64'(100 + i));
            check("tbl_imm_x32", out_imm32, vecs[i].imm[31:0]);
            check("tbl_illegal_x32", out_illegal32, vecs[i].ill);
        end
        tick();

        // Backpressure: A then B fill both slots, then drain in order.
        fill_two();
        check("bp_in_ready_full", in_ready, 1'b0);
        drive(1'b0, 32'h0, 3'd0, '0);
        out_ready = 1'b1;
        check("bp_first_valid", out_valid, 1'b1);
        check("bp_first_tag", out_tag, 64'hA);
        tick();
        check("bp_second_valid", out_valid, 1'b1);
        check("bp_second_tag", out_tag, 64'hB);
        check("bp_in_ready_back", in_ready, 1'b1);
        tick();
        check("bp_drained", out_valid, 1'b0);

        // Streaming 100 back-to-back entries from a fresh reset.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, $urandom, 3'($urandom_range(0, 7)), 64'(1000 + i));
            tick();
            check("stream_no_bubble", out_valid, 1'b1);
        end
        drive(1'b0, 32'h0, 3'd0, '0);
        tick();
        check("stream_out_count", n_out - n0, 100);
        check("stream_acc_cnt", acc_cnt, 32'd100);

        // Randomized traffic with occasional flush.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), $urandom, 3'($urandom_range(0, 7)), {$urandom, $urandom});
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            tick();
        end
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, '0);
        out_ready = 1'b1;
        repeat (3) tick();

        // Flush with both slots full and a simultaneous input.
        fill_two();
        acc_saved = acc_model;
        flush = 1'b1;
        drive(1'b1, 32'hFFDFF06F, 3'd4, 64'hC);
        tick();
        check("flush_out_valid", out_valid, 1'b0);
        check("flush_in_ready", in_ready, 1'b1);
        check("flush_acc_cnt", acc_cnt, acc_saved);
        flush = 1'b0;
        drive(1'b0, 32'h0, 3'd0, '0);
        out_ready = 1'b1;
        repeat (3) tick();
        check("flush_no_ghost", out_valid, 1'b0);

        // Reset mid-operation with both slots full and a handshake offered.
        fill_two();
        rst_n = 1'b0;
        drive(1'b1, 32'h3002D073, 3'd6, 64'hD);
        tick();
        check("mrst_out_valid", out_valid, 1'b0);
        check("mrst_acc_cnt", acc_cnt, '0);
        check("mrst_out_imm", out_imm, '0);
        check("mrst_out_tag", out_tag, '0);
        check("mrst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 3'd0, '0);
        out_ready = 1'b1;
        tick();
        check("mrst_no_partial", out_valid, 1'b0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
